// File: rtl/mx_seq_pkg.sv
// mx_seq_pkg: shared op and FSM state encodings for the matrix sequencer
// Contents: mx_op_e (MSCALE/MADDS/MSUM/MDOT), mx_state_e (IDLE/RUN/DONE), is_reduction()
package mx_seq_pkg;
    typedef enum logic [1:0] {
        MSCALE = 2'b00,
        MADDS  = 2'b01,
        MSUM   = 2'b10,
        MDOT   = 2'b11
    } mx_op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } mx_state_e;
    function automatic logic is_reduction(input mx_op_e op);
        return op == MSUM || op == MDOT;
    endfunction
endpackage

// File: rtl/mx_seq_if.sv
// mx_seq_if: EX-stage <-> matrix sequencer handshake and operand/result bus
// master: drives mx_start/mx_op/mx_op_m/mx_op_a/mx_flush, sees mx_stall/mx_done/results
// slave:  the sequencer side of the same signals
interface mx_seq_if #(
    parameter int LANES = 4,
    parameter int LW    = 32
);
    logic                mx_start;
    logic [1:0]          mx_op;
    logic [LANES*LW-1:0] mx_op_m;
    logic [LW-1:0]       mx_op_a;
    logic                mx_flush;
    logic                mx_stall;
    logic                mx_done;
    logic [LANES*LW-1:0] mx_matrix_o;
    logic [LW-1:0]       mx_scalar_o;
    modport master (
        output mx_start, mx_op, mx_op_m, mx_op_a, mx_flush,
        input  mx_stall, mx_done, mx_matrix_o, mx_scalar_o
    );
    modport slave (
        input  mx_start, mx_op, mx_op_m, mx_op_a, mx_flush,
        output mx_stall, mx_done, mx_matrix_o, mx_scalar_o
    );
endinterface

// File: rtl/mx_seq_lane_alu.sv
// mx_lane_alu: combinational lane unit shared by all lanes of one operation
// i_op: operation, i_m: current lane operand, i_a: scalar, i_acc: running reduction
// o_res: lane result (MSCALE/MADDS) or updated accumulator (MSUM/MDOT)
module mx_lane_alu
    import mx_seq_pkg::*;
#(
    parameter int LW = 32
) (
    input  mx_op_e        i_op,
    input  logic [LW-1:0] i_m,
    input  logic [LW-1:0] i_a,
    input  logic [LW-1:0] i_acc,
    output logic [LW-1:0] o_res
);
    logic [LW-1:0] w_prod;
    assign w_prod = i_m * i_a;
    always_comb begin
        o_res = i_op == MSCALE ? w_prod :
                i_op == MADDS  ? i_m + i_a :
                i_op == MSUM   ? i_acc + i_m :
                                 i_acc + w_prod;
    end
endmodule

// File: rtl/mx_seq.sv
// mx_seq: multi-cycle matrix sequencer, one lane per cycle through a shared lane ALU
// clk, rstn (async active-low); bus (slave): start/op/operands/flush in,
// stall/done/matrix/scalar results out
module mx_seq
    import mx_seq_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = 32
) (
    input logic  clk,
    input logic  rstn,
    mx_seq_if.slave bus
);
    localparam int CW = LANES > 1 ? $clog2(LANES) : 1;
    mx_state_e           r_state, w_next;
    mx_op_e              r_op;
    logic [CW-1:0]       r_lane;
    logic [LANES*LW-1:0] r_m, r_mat;
    logic [LW-1:0]       r_a, r_acc, w_lane_m, w_res;
    logic                w_accept, w_last;
    assign w_accept = r_state == ST_IDLE && bus.mx_start && !bus.mx_flush;
    assign w_last   = r_lane == CW'(LANES - 1);
    assign w_lane_m = r_m[r_lane*LW +: LW];
    mx_lane_alu #(.LW(LW)) u_alu (
        .i_op  (r_op),
        .i_m   (w_lane_m),
        .i_a   (r_a),
        .i_acc (r_acc),
        .o_res (w_res)
    );
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end
    // stall/done are gated by rstn so reset silences them even with inputs high
    always_comb begin
        w_next = bus.mx_flush        ? ST_IDLE :
                 r_state == ST_IDLE ? (bus.mx_start ? ST_RUN : ST_IDLE) :
                 r_state == ST_RUN  ? (w_last ? ST_DONE : ST_RUN) :
                                      ST_IDLE;
        bus.mx_stall = rstn && (w_accept || (r_state == ST_RUN && !bus.mx_flush));
        bus.mx_done  = rstn && r_state == ST_DONE && !bus.mx_flush;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_op   <= MSCALE;
            r_m    <= '0;
            r_a    <= '0;
            r_lane <= '0;
            r_acc  <= '0;
            r_mat  <= '0;
        end else if (bus.mx_flush) begin
            r_lane <= '0;
            r_acc  <= '0;
            r_mat  <= '0;
        end else if (w_accept) begin
            r_op   <= mx_op_e'(bus.mx_op);
            r_m    <= bus.mx_op_m;
            r_a    <= bus.mx_op_a;
            r_lane <= '0;
            r_acc  <= '0;
            r_mat  <= '0;
        end else if (r_state == ST_RUN) begin
            r_lane <= w_last ? '0 : r_lane + 1'b1;
            if (is_reduction(r_op)) r_acc <= w_res;
            else                    r_mat[r_lane*LW +: LW] <= w_res;
        end
    end
    assign bus.mx_matrix_o = r_mat;
    assign bus.mx_scalar_o = r_acc;
endmodule

// File: tb/tb_mx_seq.sv
// tb_mx_seq: directed stimulus with a per-cycle reference model of the matrix sequencer
module tb_mx_seq;
    import mx_seq_pkg::*;
    localparam int L = 4;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    always #5 clk = ~clk;
    mx_seq_if #(.LANES(L), .LW(32)) bus ();
    mx_seq #(.LANES(L), .LW(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void calc(input logic [1:0] op, input logic [127:0] m, input logic [31:0] a,
                                 output logic [127:0] mat, output logic [31:0] sc);
        mat = '0;
        sc  = '0;
        for (int i = 0; i < L; i++) begin
            logic [31:0] mi, p, s;
            mi = m[32*i +: 32];
            p  = mi * a;
            s  = mi + a;
            if (op == MSCALE)     mat[32*i +: 32] = p;
            else if (op == MADDS) mat[32*i +: 32] = s;
            else if (op == MSUM)  sc = sc + mi;
            else                  sc = sc + p;
        end
    endfunction

    // ph: 0 idle, 1..L busy lanes, L+1 done cycle
    int           ph = 0;
    logic [127:0] e_mat = '0;
    logic [31:0]  e_sc = '0;
    always @(negedge clk) begin
        if (!rstn) begin
            chk("m_rst_stall", bus.mx_stall, 0);
            chk("m_rst_done", bus.mx_done, 0);
            chk("m_rst_mat", bus.mx_matrix_o, 0);
            chk("m_rst_sc", bus.mx_scalar_o, 0);
            ph = 0;
            e_mat = '0;
            e_sc = '0;
        end else begin
            chk("m_stall", bus.mx_stall, ((ph == 0 && bus.mx_start) || (ph >= 1 && ph <= L)) && !bus.mx_flush);
            chk("m_done", bus.mx_done, ph == L + 1 && !bus.mx_flush);
            if (ph == 0 || ph == L + 1) begin
                chk("m_mat", bus.mx_matrix_o, e_mat);
                chk("m_sc", bus.mx_scalar_o, e_sc);
            end
            if (bus.mx_flush) begin
                ph = 0;
                e_mat = '0;
                e_sc = '0;
            end else if (ph == 0) begin
                if (bus.mx_start) begin
                    ph = 1;
                    calc(bus.mx_op, bus.mx_op_m, bus.mx_op_a, e_mat, e_sc);
                end
            end else begin
                ph = ph == L + 1 ? 0 : ph + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [1:0] op, input logic [127:0] m, input logic [31:0] a);
        bus.mx_start = s;
        bus.mx_op    = op;
        bus.mx_op_m  = m;
        bus.mx_op_a  = a;
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [127:0] m, input logic [31:0] a,
                          input logic [127:0] x_mat, input logic [31:0] x_sc);
        drive(1'b1, op, m, a);
        cyc();
        bus.mx_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mx_done) break;
            cyc();
        end
        chk({nm, "_done"}, bus.mx_done, 1);
        chk({nm, "_mat"}, bus.mx_matrix_o, x_mat);
        chk({nm, "_sc"}, bus.mx_scalar_o, x_sc);
        cyc();
    endtask

    initial begin
        drive(1'b1, MSCALE, '0, '0);
        bus.mx_flush = 1'b0;
        #2;
        chk("rst_stall", bus.mx_stall, 0);
        chk("rst_done", bus.mx_done, 0);
        chk("rst_mat", bus.mx_matrix_o, 0);
        chk("rst_sc", bus.mx_scalar_o, 0);
        bus.mx_start = 1'b0;
        repeat (2) cyc();
        rstn = 1'b1;
        drive(1'b1, MSCALE, 128'h00000004_00000003_00000002_00000001, 32'd2);
        #1;
        chk("c0_stall", bus.mx_stall, 1);
        for (int c = 1; c <= 5; c++) begin
            cyc();
            bus.mx_start = 1'b0;
            chk($sformatf("c%0d_stall", c), bus.mx_stall, c < 5);
            chk($sformatf("c%0d_done", c), bus.mx_done, c == 5);
        end
        chk("mscale_mat", bus.mx_matrix_o, 128'h00000008_00000006_00000004_00000002);
        cyc();
        run_op("mdot_wrap", MDOT, {4{32'h80000000}}, 32'd2, '0, '0);
        run_op("msum_wrap", MSUM, {4{32'hFFFFFFFF}}, 32'd0, '0, 32'hFFFFFFFC);
        run_op("madds", MADDS, 128'h00000028_0000001E_00000014_0000000A, 32'd5,
               128'h0000002D_00000023_00000019_0000000F, '0);
        run_op("mdot", MDOT, 128'h00000004_00000003_00000002_00000001, 32'd3, '0, 32'd30);
        run_op("mscale_big", MSCALE, 128'h00010000_FFFFFFFF_00000007_12345678, 32'h10,
               128'h00100000_FFFFFFF0_00000070_23456780, '0);
        repeat (3) cyc();
        chk("hold_mat", bus.mx_matrix_o, 128'h00100000_FFFFFFF0_00000070_23456780);
        drive(1'b1, MADDS, 128'h00000001_00000002_00000003_00000004, 32'd7);
        cyc();
        bus.mx_start = 1'b0;
        cyc();
        bus.mx_flush = 1'b1;
        #1;
        chk("flush_stall", bus.mx_stall, 0);
        chk("flush_done", bus.mx_done, 0);
        cyc();
        bus.mx_flush = 1'b0;
        chk("flush_mat", bus.mx_matrix_o, 0);
        chk("flush_sc", bus.mx_scalar_o, 0);
        chk("flush_idle_stall", bus.mx_stall, 0);
        repeat (6) begin
            cyc();
            chk("flush_nodone", bus.mx_done, 0);
        end
        drive(1'b1, MSUM, 128'h00000001_00000001_00000001_00000001, 32'd0);
        bus.mx_flush = 1'b1;
        #1;
        chk("sf_stall", bus.mx_stall, 0);
        cyc();
        bus.mx_start = 1'b0;
        bus.mx_flush = 1'b0;
        repeat (6) begin
            cyc();
            chk("sf_nodone", bus.mx_done, 0);
        end
        drive(1'b1, MSUM, 128'h00000004_00000003_00000002_00000001, 32'd0);
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 7) drive(1'b0, MSCALE, {4{32'hFFFFFFFF}}, 32'd9);
            chk($sformatf("held_done_c%0d", c), bus.mx_done, c == 5 || c == 11);
            if (c == 6) chk("restart_stall", bus.mx_stall, 1);
            if (c == 5 || c == 11) begin
                chk($sformatf("held_sc_c%0d", c), bus.mx_scalar_o, 32'd10);
                chk($sformatf("held_mat_c%0d", c), bus.mx_matrix_o, 0);
            end
        end
        cyc();
        drive(1'b1, MSCALE, {4{32'h5}}, 32'd3);
        cyc();
        bus.mx_start = 1'b0;
        cyc();
        rstn = 1'b0;
        #1;
        chk("rst2_mat", bus.mx_matrix_o, 0);
        chk("rst2_sc", bus.mx_scalar_o, 0);
        chk("rst2_stall", bus.mx_stall, 0);
        chk("rst2_done", bus.mx_done, 0);
        cyc();
        rstn = 1'b1;
        repeat (7) begin
            cyc();
            chk("rst2_nodone", bus.mx_done, 0);
        end
        run_op("madds_wrap", MADDS, {4{32'h1}}, 32'hFFFFFFFF, '0, '0);
        repeat (2) cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
